// File: rtl/burst_read_ram_if.sv
// Bus bundle for burst_read_ram: write port, burst request and packed read-back handshake.
interface burst_read_ram_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
);
    logic                            we;
    logic [ADDR_WIDTH-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]           wr_data;
    logic                            rd_start;
    logic [ADDR_WIDTH-1:0]           rd_base;
    logic                            rd_ready;
    logic                            rd_busy;
    logic                            rd_valid;
    logic [BURST_LEN*DATA_WIDTH-1:0] rd_data;
    logic                            rd_drop;

    modport master (
        output we, wr_addr, wr_data, rd_start, rd_base, rd_ready,
        input  rd_busy, rd_valid, rd_data, rd_drop
    );

    modport slave (
        input  we, wr_addr, wr_data, rd_start, rd_base, rd_ready,
        output rd_busy, rd_valid, rd_data, rd_drop
    );
endinterface

// File: rtl/burst_read_ram.sv
// Word store with a sequential burst-read engine returning BURST_LEN words on one wide bus.
// Define WRITE_FORWARD_EN to let a same-edge write to the captured address reach the slot.
module burst_read_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input logic             clk,
    input logic             rst_n,
    burst_read_ram_if.slave bus
);
    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                base_q, base_d;
    logic [CNT_W-1:0]                     idx_q, idx_d;
    logic [BURST_LEN-1:0][DATA_WIDTH-1:0] slot_q, slot_d;
    logic                                 valid_q, valid_d;
    logic                                 busy_q, busy_d;
    logic                                 drop_q, drop_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_word;

    // Contents survive reset; only the write is suppressed while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n && bus.we) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign cap_addr = base_q + ADDR_WIDTH'(idx_q);

`ifdef WRITE_FORWARD_EN
    assign cap_word = (bus.we && (bus.wr_addr == cap_addr)) ? bus.wr_data : mem[cap_addr];
`else
    assign cap_word = mem[cap_addr];
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        drop_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.rd_start) begin
                    base_d  = bus.rd_base;
                    idx_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                slot_d[idx_q] = cap_word;
                drop_d        = bus.rd_start;
                if (idx_q == LAST_IDX) begin
                    valid_d = 1'b1;
                    state_d = StHold;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (bus.rd_ready) begin
                    valid_d = 1'b0;
                    if (bus.rd_start) begin
                        base_d  = bus.rd_base;
                        idx_d   = '0;
                        state_d = StFetch;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    drop_d = bus.rd_start;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            idx_q   <= '0;
            slot_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.rd_busy  = busy_q;
    assign bus.rd_valid = valid_q;
    assign bus.rd_data  = slot_q;
    assign bus.rd_drop  = drop_q;
endmodule

// File: tb/tb_burst_read_ram.sv
// Bench for burst_read_ram: queue-based reference model checked every cycle, plus directed cases.
module tb_burst_read_ram;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int W  = BL * DW;

    localparam logic [W-1:0] T1_DATA   = 128'h00000044_00000033_00000022_00000011;
    localparam logic [W-1:0] T2_DATA   = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [W-1:0] T5_NEW    = 128'h00000044_0000AAAA_00000022_00000011;
`ifdef WRITE_FORWARD_EN
    localparam logic [W-1:0] T5_FIRST  = T5_NEW;
`else
    localparam logic [W-1:0] T5_FIRST  = T1_DATA;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    burst_read_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) bus ();

    burst_read_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model: a burst is a queue of addresses, one popped and captured per edge.
    logic [DW-1:0]         ref_mem [2**AW];
    logic [AW-1:0]         fetch_q [$];
    logic [BL-1:0][DW-1:0] m_data  = '0;
    logic                  m_valid = 1'b0;
    logic                  m_busy  = 1'b0;
    logic                  m_drop  = 1'b0;

    always @(posedge clk) begin : model_blk
        int            slot;
        logic [AW-1:0] a;
        logic          accept;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_drop  = 1'b0;
            m_data  = '0;
            fetch_q.delete();
        end else begin
            accept = 1'b0;
            m_drop = 1'b0;
            if (fetch_q.size() != 0) begin
                slot = BL - fetch_q.size();
                a = fetch_q.pop_front();
                m_data[slot] = ref_mem[a];
`ifdef WRITE_FORWARD_EN
                if (bus.we && bus.wr_addr == a) m_data[slot] = bus.wr_data;
`endif
                if (fetch_q.size() == 0) m_valid = 1'b1;
                m_drop = bus.rd_start;
            end else if (m_valid) begin
                if (bus.rd_ready) begin
                    m_valid = 1'b0;
                    accept  = bus.rd_start;
                end else begin
                    m_drop = bus.rd_start;
                end
            end else begin
                accept = bus.rd_start;
            end
            if (accept) begin
                for (int i = 0; i < BL; i++) fetch_q.push_back(bus.rd_base + AW'(i));
            end
            m_busy = m_valid || (fetch_q.size() != 0);
            if (bus.we) ref_mem[bus.wr_addr] = bus.wr_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", W'(bus.rd_busy), W'(m_busy));
            check("model_valid", W'(bus.rd_valid), W'(m_valid));
            check("model_drop", W'(bus.rd_drop), W'(m_drop));
            if (m_valid) check("model_data", bus.rd_data, m_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.we = 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] b);
        bus.rd_start = 1'b1;
        bus.rd_base = b;
        step();
        bus.rd_start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.rd_valid && n < 50) begin
            step();
            n++;
        end
        check("wait_valid", W'(bus.rd_valid), W'(1));
    endtask

    task automatic release_burst();
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        int n;
        int valid_at [$];
        int drops;
        bus.we = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_start = 1'b0;
        bus.rd_base = '0;
        bus.rd_ready = 1'b0;

        // Reset state
        step();
        chk_en = 1'b1;
        step();
        check("rst_busy", W'(bus.rd_busy), W'(0));
        check("rst_valid", W'(bus.rd_valid), W'(0));
        check("rst_drop", W'(bus.rd_drop), W'(0));
        check("rst_data", bus.rd_data, '0);
        rst_n = 1'b1;
        for (int a = 0; a < 2**AW; a++) wr(AW'(a), $urandom);

        // T1 basic burst and latency
        wr(8'h10, 32'h11); wr(8'h11, 32'h22); wr(8'h12, 32'h33); wr(8'h13, 32'h44);
        bus.rd_ready = 1'b1;
        start(8'h10);
        check("t1_busy", W'(bus.rd_busy), W'(1));
        wait_valid(n);
        check("t1_latency", W'(n), W'(BL));
        check("t1_data", bus.rd_data, T1_DATA);
        step();
        check("t1_valid_clr", W'(bus.rd_valid), W'(0));
        check("t1_idle", W'(bus.rd_busy), W'(0));
        bus.rd_ready = 1'b0;

        // T2 address wrap
        wr(8'hFE, 32'hA0); wr(8'hFF, 32'hA1); wr(8'h00, 32'hA2); wr(8'h01, 32'hA3);
        start(8'hFE);
        wait_valid(n);
        check("t2_data", bus.rd_data, T2_DATA);
        release_burst();

        // T3 backpressure and dropped start
        start(8'h10);
        wait_valid(n);
        for (int k = 0; k < 10; k++) begin
            bus.rd_start = (k == 3);
            step();
            bus.rd_start = 1'b0;
            check("t3_valid", W'(bus.rd_valid), W'(1));
            check("t3_data", bus.rd_data, T1_DATA);
            check("t3_drop", W'(bus.rd_drop), W'(k == 3));
        end
        release_burst();
        check("t3_valid_clr", W'(bus.rd_valid), W'(0));
        check("t3_idle", W'(bus.rd_busy), W'(0));
        step();
        check("t3_no_new", W'(bus.rd_busy), W'(0));

        // T4 back-to-back bursts: start offered at every acceptance edge
        bus.rd_ready = 1'b1;
        bus.rd_base = 8'h10;
        drops = 0;
        for (int s = 1; s <= 20; s++) begin
            bus.rd_start = ((s - 1) % (BL + 1) == 0);
            step();
            if (bus.rd_valid) begin
                valid_at.push_back(s);
                check("t4_data", bus.rd_data, T1_DATA);
            end
            if (bus.rd_drop) drops++;
        end
        bus.rd_start = 1'b0;
        check("t4_bursts", W'(valid_at.size()), W'(4));
        for (int i = 1; i < valid_at.size(); i++) begin
            check("t4_period", W'(valid_at[i] - valid_at[i-1]), W'(BL + 1));
        end
        check("t4_drops", W'(drops), W'(0));
        step();
        check("t4_idle", W'(bus.rd_busy), W'(0));
        bus.rd_ready = 1'b0;

        // T5 write colliding with the slot-2 capture edge
        start(8'h10);
        step();
        step();
        wr(8'h12, 32'hAAAA);
        wait_valid(n);
        check("t5_first", bus.rd_data, T5_FIRST);
        release_burst();
        start(8'h10);
        wait_valid(n);
        check("t5_second", bus.rd_data, T5_NEW);
        release_burst();

        // T6 reset mid-fetch; the write presented during reset must be ignored
        wr(8'h12, 32'h33);
        start(8'h10);
        step();
        step();
        rst_n = 1'b0;
        wr(8'h10, 32'hDEAD);
        check("t6_busy", W'(bus.rd_busy), W'(0));
        check("t6_valid", W'(bus.rd_valid), W'(0));
        check("t6_drop", W'(bus.rd_drop), W'(0));
        check("t6_data", bus.rd_data, '0);
        rst_n = 1'b1;
        step();
        start(8'h10);
        wait_valid(n);
        check("t6_data_after", bus.rd_data, T1_DATA);
        release_burst();

        // Randomised traffic, addresses biased into a small window to provoke collisions
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            bus.we = $urandom_range(0, 1) == 1;
            bus.wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            bus.wr_data = $urandom;
            bus.rd_start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       bus.rd_base = AW'($urandom_range(0, 15));
                1:       bus.rd_base = AW'($urandom_range(8'hFA, 8'hFF));
                default: bus.rd_base = AW'($urandom);
            endcase
            bus.rd_ready = $urandom_range(0, 1) == 1;
            step();
        end
        rst_n = 1'b1;
        bus.we = 1'b0;
        bus.rd_start = 1'b0;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 2 * BL + 4; c++) step();
        check("final_idle", W'(bus.rd_busy), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
